// File: rtl/inst_cache_if.sv
// Request/response bus shared by the core-side fetch port and the ROM-side refill port.
// master issues ren/addr; slave returns data and a stall flag.
interface inst_cache_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  ren;
  logic [ADDR_WIDTH-1:0] addr;
  logic [31:0]           data;
  logic                  stall;

  modport master (output ren, addr, input data, stall);
  modport slave  (input ren, addr, output data, stall);
endinterface

// File: rtl/inst_cache.sv
// Direct-mapped read-only instruction cache: same-cycle hits, whole-line refill
// from a multi-cycle ROM one word per transaction with a one-cycle gap between words.
module inst_cache #(
  parameter int ADDR_WIDTH  = 32,
  parameter int INDEX_WIDTH = 4,
  parameter int WORD_WIDTH  = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  inst_cache_if.slave   cpu,
  inst_cache_if.master  mem
);
  localparam int TAG_WIDTH = ADDR_WIDTH - INDEX_WIDTH - WORD_WIDTH - 2;
  localparam int LINES     = 1 << INDEX_WIDTH;
  localparam int WORDS     = 1 << WORD_WIDTH;

  typedef enum logic [1:0] {IDLE, REQ, GAP} state_t;

  state_t                  state;
  logic [WORD_WIDTH-1:0]   wcnt;
  logic [TAG_WIDTH-1:0]    miss_tag;
  logic [INDEX_WIDTH-1:0]  miss_index;
  logic                    mem_ren_r;
  logic [ADDR_WIDTH-1:0]   mem_addr_r;

  logic [LINES-1:0]        valid;
  logic [TAG_WIDTH-1:0]    tag_arr  [LINES];
  logic [31:0]             data_arr [LINES][WORDS];

  logic [TAG_WIDTH-1:0]    tag;
  logic [INDEX_WIDTH-1:0]  index;
  logic [WORD_WIDTH-1:0]   word;
  logic                    hit;
  logic                    fill_word;
  logic                    fill_last;
  logic                    unused_offset;

  assign word          = cpu.addr[WORD_WIDTH+1:2];
  assign index         = cpu.addr[WORD_WIDTH+2 +: INDEX_WIDTH];
  assign tag           = cpu.addr[ADDR_WIDTH-1 -: TAG_WIDTH];
  assign unused_offset = ^cpu.addr[1:0];

  // Hits are only served from IDLE so a line under refill never returns stale words.
  assign hit = cpu.ren && valid[index] && (tag_arr[index] == tag) && (state == IDLE);

  assign cpu.data  = hit ? data_arr[index][word] : 32'h0;
  assign cpu.stall = cpu.ren && !hit;

  assign mem.ren  = mem_ren_r;
  assign mem.addr = mem_addr_r;

  assign fill_word = (state == REQ) && !mem.stall && !flush;
  assign fill_last = fill_word && (&wcnt);

  // Refill sequencer; flush wins over every state and never lets a partial line go valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      wcnt       <= '0;
      valid      <= '0;
      miss_tag   <= '0;
      miss_index <= '0;
      mem_ren_r  <= 1'b0;
      mem_addr_r <= '0;
    end else if (flush) begin
      state      <= IDLE;
      wcnt       <= '0;
      valid      <= '0;
      mem_ren_r  <= 1'b0;
      mem_addr_r <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cpu.ren && !hit) begin
            miss_tag   <= tag;
            miss_index <= index;
            wcnt       <= '0;
            mem_ren_r  <= 1'b1;
            mem_addr_r <= {tag, index, {WORD_WIDTH{1'b0}}, 2'b00};
            state      <= REQ;
          end
        end
        REQ: begin
          if (!mem.stall) begin
            mem_ren_r <= 1'b0;
            if (&wcnt) begin
              valid[miss_index] <= 1'b1;
              wcnt              <= '0;
              mem_addr_r        <= '0;
              state             <= IDLE;
            end else begin
              wcnt  <= wcnt + 1'b1;
              state <= GAP;
            end
          end
        end
        GAP: begin
          // Dropping ren for this cycle lets the ROM restart its latency counter.
          mem_ren_r  <= 1'b1;
          mem_addr_r <= {miss_tag, miss_index, wcnt, 2'b00};
          state      <= REQ;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Tag and data storage carry no reset; valid bits alone decide whether a line is usable.
  always_ff @(posedge clk) begin
    if (fill_word) begin
      data_arr[miss_index][wcnt] <= mem.data;
    end
    if (fill_last) begin
      tag_arr[miss_index] <= miss_tag;
    end
  end
endmodule

// File: tb/tb_inst_cache.sv
// Scoreboard bench for inst_cache: stimulus queues expected fetch data and ROM addresses,
// negedge monitors pop and compare whenever a hit or ROM transfer appears.
module tb_inst_cache;
  localparam int D = 8;

  logic clk;
  logic rst;
  logic flush;

  inst_cache_if #(.ADDR_WIDTH(32)) cpu_bus ();
  inst_cache_if #(.ADDR_WIDTH(32)) mem_bus ();

  inst_cache dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .cpu   (cpu_bus),
    .mem   (mem_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vec_count  = 0;
  int miscompares = 0;

  logic [31:0] exp_q[$];
  logic [31:0] mem_q[$];

  // ROM content is a simple function of address so every word is distinguishable.
  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return 32'hA500_0000 | {8'h00, a[23:0]};
  endfunction

  // ROM model: busy for D cycles after ren rises, restarts whenever ren drops.
  int rom_cnt;
  always @(posedge clk or posedge rst) begin
    if (rst) rom_cnt <= 0;
    else if (!mem_bus.ren) rom_cnt <= 0;
    else if (rom_cnt < D) rom_cnt <= rom_cnt + 1;
  end
  assign mem_bus.stall = mem_bus.ren && (rom_cnt < D);
  assign mem_bus.data  = rom_word(mem_bus.addr);

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    vec_count++;
    if (act !== req) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic reportUnexpected(input string name, input logic [31:0] act);
    vec_count++;
    miscompares++;
    $display("[TB] FAIL %s: got %h, expected nothing queued", name, act);
  endtask

  always @(negedge clk) begin
    if (cpu_bus.ren === 1'b1 && cpu_bus.stall === 1'b0) begin
      if (exp_q.size() == 0) reportUnexpected("cpu_data_unexpected", cpu_bus.data);
      else checkOutput("cpu_data", cpu_bus.data, exp_q.pop_front());
    end
    if (mem_bus.ren === 1'b1 && mem_bus.stall === 1'b0) begin
      if (mem_q.size() == 0) reportUnexpected("mem_addr_unexpected", mem_bus.addr);
      else checkOutput("mem_addr", mem_bus.addr, mem_q.pop_front());
    end
  end

  task automatic pushLine(input logic [31:0] addr);
    logic [31:0] base;
    base = addr & ~32'hF;
    for (int w = 0; w < 4; w++) mem_q.push_back(base + 32'(4 * w));
  endtask

  // Entered and left at posedge+1; counts stalled cycles until the fetch is served.
  task automatic applyStimulus(input logic [31:0] addr, input int exp_stall, input logic [31:0] exp_data);
    int stalls;
    bit served;
    stalls = 0;
    served = 0;
    exp_q.push_back(exp_data);
    if (exp_stall > 0) pushLine(addr);
    cpu_bus.ren  = 1'b1;
    cpu_bus.addr = addr;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (cpu_bus.stall) stalls++;
      else begin
        served = 1;
        break;
      end
    end
    if (!served) $display("[TB] FAIL fetch_timeout: addr %h never served", addr);
    checkOutput("stall_cycles", 32'(stalls), 32'(exp_stall));
    checkOutput("mem_ren_on_hit", {31'b0, mem_bus.ren}, 32'h0);
    @(posedge clk);
    #1;
  endtask

  task automatic waitMemAddr(input logic [31:0] addr);
    bit seen;
    seen = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (mem_bus.ren && mem_bus.addr == addr) begin
        seen = 1;
        break;
      end
    end
    checkOutput("wait_mem_addr", {31'b0, seen}, 32'h1);
  endtask

  typedef struct {
    logic [31:0] addr;
    int          stall;
    logic [31:0] data;
  } vec_t;

  vec_t basic_vecs[10] = '{
    '{32'h0000_0000, 40, 32'hA500_0000},
    '{32'h0000_0004,  0, 32'hA500_0004},
    '{32'h0000_0008,  0, 32'hA500_0008},
    '{32'h0000_000C,  0, 32'hA500_000C},
    '{32'h0000_0100, 40, 32'hA500_0100},
    '{32'h0000_0000, 40, 32'hA500_0000},
    '{32'h0000_0004,  0, 32'hA500_0004},
    '{32'h0000_1234, 40, 32'hA500_1234},
    '{32'h0000_1238,  0, 32'hA500_1238},
    '{32'h0000_1230,  0, 32'hA500_1230}
  };

  initial begin
    rst          = 1'b1;
    flush        = 1'b0;
    cpu_bus.ren  = 1'b1;
    cpu_bus.addr = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_cpu_stall", {31'b0, cpu_bus.stall}, 32'h1);
    checkOutput("reset_cpu_data", cpu_bus.data, 32'h0);
    checkOutput("reset_mem_ren", {31'b0, mem_bus.ren}, 32'h0);
    checkOutput("reset_mem_addr", mem_bus.addr, 32'h0);
    rst = 1'b0;

    for (int v = 0; v < 10; v++)
      applyStimulus(basic_vecs[v].addr, basic_vecs[v].stall, basic_vecs[v].data);

    // Flush while the third word of line 4 is outstanding.
    mem_q.push_back(32'h40);
    mem_q.push_back(32'h44);
    cpu_bus.ren  = 1'b1;
    cpu_bus.addr = 32'h40;
    waitMemAddr(32'h48);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    checkOutput("flush_mem_ren", {31'b0, mem_bus.ren}, 32'h0);
    checkOutput("flush_cpu_stall", {31'b0, cpu_bus.stall}, 32'h1);
    applyStimulus(32'h40, 40, 32'hA500_0040);
    applyStimulus(32'h4C, 0, 32'hA500_004C);
    applyStimulus(32'h00, 40, 32'hA500_0000);

    // Asynchronous reset in the middle of a refill.
    mem_q.push_back(32'h80);
    cpu_bus.ren  = 1'b1;
    cpu_bus.addr = 32'h80;
    waitMemAddr(32'h84);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_rst_mem_ren", {31'b0, mem_bus.ren}, 32'h0);
    checkOutput("async_rst_mem_addr", mem_bus.addr, 32'h0);
    checkOutput("async_rst_cpu_stall", {31'b0, cpu_bus.stall}, 32'h1);
    checkOutput("async_rst_cpu_data", cpu_bus.data, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    applyStimulus(32'h40, 40, 32'hA500_0040);
    applyStimulus(32'h00, 40, 32'hA500_0000);
    applyStimulus(32'h80, 40, 32'hA500_0080);

    // Dropping cpu_ren mid-miss must not abort the refill.
    pushLine(32'hC0);
    cpu_bus.ren  = 1'b1;
    cpu_bus.addr = 32'hC0;
    @(posedge clk);
    #1;
    cpu_bus.ren = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (mem_q.size() == 0) break;
    end
    checkOutput("orphan_refill_done", 32'(mem_q.size()), 32'h0);
    @(posedge clk);
    #1;
    applyStimulus(32'hC4, 0, 32'hA500_00C4);
    applyStimulus(32'hC0, 0, 32'hA500_00C0);
    cpu_bus.ren = 1'b0;

    repeat (3) @(posedge clk);
    checkOutput("exp_q_drained", 32'(exp_q.size()), 32'h0);
    checkOutput("mem_q_drained", 32'(mem_q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end
endmodule
